// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SHIFT    = 2'd1,
      LOAD_OUT = 2'd2
   } state_t;

   localparam int          DIGIT_W    = 4;
   localparam logic [3:0]  ADJ_THRESH = 4'd5;
   localparam logic [3:0]  ADJ_ADD    = 4'd3;
   localparam logic [3:0]  BCD_NINE   = 4'h9;

endpackage

// File: rtl/bcd_digit_adjust.sv
// Double-dabble digit correction: add 3 to a BCD digit that is 5 or more.
module bcd_digit_adjust
   import bcd_pkg::*;
(
   input  logic [DIGIT_W-1:0] din,
   output logic [DIGIT_W-1:0] dout
);

   // 4-bit wrap is intended; a corrected digit never carries into its neighbour.
   assign dout = (din >= ADJ_THRESH) ? din + ADJ_ADD : din;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: one shift per clock, start/done framed,
// result held steady for the display driver between conversions.
module bin_to_bcd_seq
   import bcd_pkg::*;
#(
   parameter int IN_W   = 13,
   parameter int DIGITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [IN_W-1:0]       bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
);

   localparam int BCD_W = DIGIT_W * DIGITS;
   localparam int CNT_W = $clog2(IN_W + 1);
   localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

   state_t             state_reg, state_next;
   logic [IN_W-1:0]    shift_reg;
   logic [BCD_W-1:0]   scratch_reg;
   logic [BCD_W-1:0]   adj;
   logic [CNT_W-1:0]   count_reg;
   logic               sticky_reg;
   logic [BCD_W-1:0]   bcd_reg;
   logic               ovf_reg;
   logic               done_reg;

   genvar gi;
   generate
      for (gi = 0; gi < DIGITS; gi++) begin : g_adj
         bcd_digit_adjust u_adj (
            .din  (scratch_reg[gi*DIGIT_W +: DIGIT_W]),
            .dout (adj[gi*DIGIT_W +: DIGIT_W])
         );
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (rst) state_reg <= IDLE;
      else     state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:     if (start) state_next = SHIFT;
         SHIFT:    if (count_reg == CNT_W'(1)) state_next = LOAD_OUT;
         LOAD_OUT: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state_reg != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shift_reg   <= '0;
         scratch_reg <= '0;
         count_reg   <= '0;
         sticky_reg  <= 1'b0;
         bcd_reg     <= '0;
         ovf_reg     <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  shift_reg   <= bin;
                  scratch_reg <= '0;
                  sticky_reg  <= 1'b0;
                  count_reg   <= CNT_W'(IN_W);
               end
            end
            SHIFT: begin
               // A 1 leaving the top digit means the value no longer fits.
               scratch_reg <= {adj[BCD_W-2:0], shift_reg[IN_W-1]};
               shift_reg   <= shift_reg << 1;
               if (adj[BCD_W-1]) sticky_reg <= 1'b1;
               count_reg   <= count_reg - CNT_W'(1);
            end
            LOAD_OUT: begin
               bcd_reg  <= sticky_reg ? ALL_NINES : scratch_reg;
               ovf_reg  <= sticky_reg;
               done_reg <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign bcd  = bcd_reg;
   assign ovf  = ovf_reg;
   assign done = done_reg;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: a 4-digit and a 3-digit instance checked against
// a decimal-arithmetic reference model.
module tb_bin_to_bcd_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        start4, start3;
   logic [12:0] bin;
   logic        busy4, done4, ovf4;
   logic        busy3, done3, ovf3;
   logic [15:0] bcd4;
   logic [11:0] bcd3;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   bin_to_bcd_seq #(.IN_W(13), .DIGITS(4)) dut (
      .clk(clk), .rst(rst), .start(start4), .bin(bin),
      .busy(busy4), .done(done4), .bcd(bcd4), .ovf(ovf4)
   );

   bin_to_bcd_seq #(.IN_W(13), .DIGITS(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bin(bin),
      .busy(busy3), .done(done3), .bcd(bcd3), .ovf(ovf3)
   );

   // Decimal digits by division; saturates to all nines when out of range.
   function automatic logic [15:0] ref_bcd(input int v, input int digits, output logic o);
      logic [15:0] r;
      int lim, t;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      o = (v >= lim);
      r = '0;
      t = v;
      for (int i = 0; i < digits; i++) begin
         r[i*4 +: 4] = o ? 4'd9 : 4'(t % 10);
         t = t / 10;
      end
      return r;
   endfunction

   // Issue one conversion and wait (bounded) for done; lat=-1 on timeout.
   task automatic do_conv(input bit use3, input int v, output int lat,
                          output logic [15:0] b, output logic o);
      @(negedge clk);
      bin = 13'(v);
      if (use3) start3 = 1'b1; else start4 = 1'b1;
      @(posedge clk); #1;
      start3 = 1'b0;
      start4 = 1'b0;
      lat = -1; b = '0; o = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (use3 ? done3 : done4) begin
            lat = n;
            b   = use3 ? {4'h0, bcd3} : bcd4;
            o   = use3 ? ovf3 : ovf4;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start4 = 1'b0; start3 = 1'b0; bin = '0;
      repeat (2) @(posedge clk);
      #1;
      tests_run++; if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%b exp=0", busy4); end
      tests_run++; if (done4 !== 1'b0) begin tests_failed++; $display("FAIL reset_done got=%b exp=0", done4); end
      tests_run++; if (bcd4 !== 16'h0) begin tests_failed++; $display("FAIL reset_bcd got=%h exp=0000", bcd4); end
      tests_run++; if (ovf4 !== 1'b0) begin tests_failed++; $display("FAIL reset_ovf got=%b exp=0", ovf4); end
      tests_run++; if (bcd3 !== 12'h0) begin tests_failed++; $display("FAIL reset_bcd3 got=%h exp=000", bcd3); end
      @(negedge clk) rst = 1'b0;
   endtask

   task automatic test_basic();
      int lat; logic [15:0] b; logic o;
      do_conv(1'b0, 0, lat, b, o);
      $display("[TB] conv bin=0 lat=%0d bcd=%h ovf=%b", lat, b, o);
      tests_run++; if (lat !== 14) begin tests_failed++; $display("FAIL zero_latency got=%0d exp=14", lat); end
      tests_run++; if (b !== 16'h0000) begin tests_failed++; $display("FAIL zero_bcd got=%h exp=0000", b); end
      tests_run++; if (o !== 1'b0) begin tests_failed++; $display("FAIL zero_ovf got=%b exp=0", o); end
      @(posedge clk); #1;
      tests_run++; if (done4 !== 1'b0) begin tests_failed++; $display("FAIL done_one_cycle got=%b exp=0", done4); end
      do_conv(1'b0, 8191, lat, b, o);
      $display("[TB] conv bin=8191 lat=%0d bcd=%h ovf=%b", lat, b, o);
      tests_run++; if (b !== 16'h8191 || lat !== 14) begin tests_failed++; $display("FAIL max_bcd got=%h lat=%0d exp=8191 lat=14", b, lat); end
      tests_run++; if (o !== 1'b0) begin tests_failed++; $display("FAIL max_ovf got=%b exp=0", o); end
   endtask

   task automatic test_sweep();
      int lat; logic [15:0] b, e; logic o, eo; int v;
      for (int i = 0; i < 303; i++) begin
         case (i)
            0:       v = 9;
            1:       v = 1000;
            2:       v = 4095;
            default: v = int'($urandom_range(0, 8191));
         endcase
         e = ref_bcd(v, 4, eo);
         do_conv(1'b0, v, lat, b, o);
         $display("[TB] conv bin=%0d bcd=%h ovf=%b exp=%h", v, b, o, e);
         tests_run++;
         if (b !== e || o !== eo || lat !== 14) begin
            tests_failed++;
            $display("FAIL sweep bin=%0d got=%h/%b lat=%0d exp=%h/%b lat=14", v, b, o, lat, e, eo);
         end
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      bit seen;
      @(negedge clk);
      bin = 13'd123; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      seen = 1'b0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done4) begin seen = 1'b1; break; end
      end
      tests_run++; if (!seen) begin tests_failed++; $display("FAIL b2b_first_done got=timeout exp=done"); end
      // Still inside the done cycle: this request must be taken at the next edge.
      bin = 13'd255; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = -1;
      for (int n = 2; n <= 40; n++) begin
         tests_run++;
         if (bcd4 !== 16'h0123) begin tests_failed++; $display("FAIL b2b_hold cyc=%0d got=%h exp=0123", n, bcd4); end
         @(posedge clk); #1;
         if (done4) begin lat = n; break; end
      end
      $display("[TB] b2b bin=255 spacing=%0d bcd=%h", lat, bcd4);
      tests_run++; if (lat !== 15) begin tests_failed++; $display("FAIL b2b_spacing got=%0d exp=15", lat); end
      tests_run++; if (bcd4 !== 16'h0255) begin tests_failed++; $display("FAIL b2b_bcd got=%h exp=0255", bcd4); end
   endtask

   task automatic test_ignore();
      int lat; int extra;
      @(negedge clk);
      bin = 13'd4321; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      lat = -1;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         if (done4) begin lat = n; break; end
         if (n == 3 || n == 10) begin start4 = 1'b1; bin = 13'd1234; end
         else begin start4 = 1'b0; bin = 13'($urandom); end
      end
      start4 = 1'b0;
      $display("[TB] ignore bin=4321 lat=%0d bcd=%h", lat, bcd4);
      tests_run++; if (lat !== 14) begin tests_failed++; $display("FAIL ignore_latency got=%0d exp=14", lat); end
      tests_run++; if (bcd4 !== 16'h4321) begin tests_failed++; $display("FAIL ignore_bcd got=%h exp=4321", bcd4); end
      extra = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (done4) extra++;
      end
      tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
   endtask

   task automatic test_reset_mid();
      int extra; int lat; logic [15:0] b; logic o;
      @(negedge clk);
      bin = 13'd5555; start4 = 1'b1;
      @(posedge clk); #1;
      start4 = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tests_run++; if (busy4 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_busy got=%b exp=0", busy4); end
      tests_run++; if (bcd4 !== 16'h0) begin tests_failed++; $display("FAIL rstmid_bcd got=%h exp=0000", bcd4); end
      tests_run++; if (ovf4 !== 1'b0) begin tests_failed++; $display("FAIL rstmid_ovf got=%b exp=0", ovf4); end
      extra = 0;
      for (int n = 0; n < 20; n++) begin
         @(posedge clk); #1;
         if (done4) extra++;
      end
      tests_run++; if (extra !== 0) begin tests_failed++; $display("FAIL rstmid_done got=%0d exp=0", extra); end
      do_conv(1'b0, 77, lat, b, o);
      $display("[TB] after reset bin=77 bcd=%h lat=%0d", b, lat);
      tests_run++; if (b !== 16'h0077 || lat !== 14) begin tests_failed++; $display("FAIL rstmid_fresh got=%h lat=%0d exp=0077 lat=14", b, lat); end
   endtask

   task automatic test_overflow();
      int lat; logic [15:0] b, e; logic o, eo; int v;
      for (int i = 0; i < 23; i++) begin
         case (i)
            0:       v = 1000;
            1:       v = 999;
            2:       v = 8191;
            default: v = int'($urandom_range(0, 2047));
         endcase
         e = ref_bcd(v, 3, eo);
         do_conv(1'b1, v, lat, b, o);
         $display("[TB] d3 conv bin=%0d bcd=%h ovf=%b exp=%h/%b", v, b[11:0], o, e[11:0], eo);
         tests_run++;
         if (b !== e || o !== eo || lat !== 14) begin
            tests_failed++;
            $display("FAIL ovf3 bin=%0d got=%h/%b lat=%0d exp=%h/%b lat=14", v, b, o, lat, e, eo);
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sweep();
      test_back_to_back();
      test_ignore();
      test_reset_mid();
      test_overflow();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
